// File: rtl/player_action_sequencer_pkg.sv
// Shared widths, button bit positions, state encodings and action lengths
// for the player action sequencer.
package player_action_sequencer_pkg;

    localparam int INPUT_DEPTH        = 5;
    localparam int STATE_DEPTH        = 3;
    localparam int SPRITE_INDEX_DEPTH = 3;

    localparam int BTN_FORWARDS  = 0;
    localparam int BTN_BACKWARDS = 1;
    localparam int BTN_GRAB      = 2;
    localparam int BTN_BLOCK     = 3;
    localparam int BTN_KICK      = 4;

    typedef enum logic [STATE_DEPTH-1:0] {
        ST_NOTHING   = 3'd0,
        ST_FORWARDS  = 3'd1,
        ST_BACKWARDS = 3'd2,
        ST_GRAB      = 3'd3,
        ST_BLOCK     = 3'd4,
        ST_KICK      = 3'd5,
        ST_WIN       = 3'd6,
        ST_LOSE      = 3'd7
    } pstate_e;

    // Action lengths in frames
    localparam int LEN_NOTHING   = 1;
    localparam int LEN_FORWARDS  = 2;
    localparam int LEN_BACKWARDS = 2;
    localparam int LEN_GRAB      = 5;
    localparam int LEN_BLOCK     = 4;
    localparam int LEN_KICK      = 6;
    localparam int LEN_WIN       = 8;
    localparam int LEN_LOSE      = 8;

    typedef logic [SPRITE_INDEX_DEPTH-1:0] sprite_t;
    typedef logic [INPUT_DEPTH-1:0]        buttons_t;

    function automatic sprite_t last_sprite(pstate_e s);
        case (s)
            ST_NOTHING:   return sprite_t'(LEN_NOTHING - 1);
            ST_FORWARDS:  return sprite_t'(LEN_FORWARDS - 1);
            ST_BACKWARDS: return sprite_t'(LEN_BACKWARDS - 1);
            ST_GRAB:      return sprite_t'(LEN_GRAB - 1);
            ST_BLOCK:     return sprite_t'(LEN_BLOCK - 1);
            ST_KICK:      return sprite_t'(LEN_KICK - 1);
            ST_WIN:       return sprite_t'(LEN_WIN - 1);
            ST_LOSE:      return sprite_t'(LEN_LOSE - 1);
            default:      return sprite_t'(0);
        endcase
    endfunction

    function automatic pstate_e button_priority(buttons_t b);
        if (b[BTN_KICK])      return ST_KICK;
        if (b[BTN_BLOCK])     return ST_BLOCK;
        if (b[BTN_GRAB])      return ST_GRAB;
        if (b[BTN_BACKWARDS]) return ST_BACKWARDS;
        if (b[BTN_FORWARDS])  return ST_FORWARDS;
        return ST_NOTHING;
    endfunction

    function automatic logic is_terminal(pstate_e s);
        return (s == ST_WIN) || (s == ST_LOSE);
    endfunction

endpackage

// File: rtl/player_action_sequencer_if.sv
// Player-facing signal bundle: button/frame inputs in, animation state out.
interface player_action_sequencer_if;
    import player_action_sequencer_pkg::*;

    logic                          frame_clk;
    logic [INPUT_DEPTH-1:0]        player_buttons;
    logic [STATE_DEPTH-1:0]        next_state;
    logic [STATE_DEPTH-1:0]        player_state;
    logic [SPRITE_INDEX_DEPTH-1:0] player_sprite;
    logic                          player_actionable;
    logic [STATE_DEPTH-1:0]        state_from_buttons;
    logic                          frame_tick;

    modport master (
        output frame_clk, player_buttons, next_state,
        input  player_state, player_sprite, player_actionable,
               state_from_buttons, frame_tick
    );

    modport slave (
        input  frame_clk, player_buttons, next_state,
        output player_state, player_sprite, player_actionable,
               state_from_buttons, frame_tick
    );

endinterface

// File: rtl/player_action_sequencer_frame_tick_gen.sv
// Synchronises the asynchronous frame_clk into sys_clk and emits a one-cycle
// pulse per rising edge.
module frame_tick_gen (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic       sync1_q, sync2_q, hist_q;
    logic       armed_q, armed_d;
    logic [1:0] fill_q, fill_d;

    // After reset the chain must first carry a real low level of frame_clk,
    // otherwise a level already high at release would look like a new edge.
    always_comb begin
        fill_d  = fill_q;
        armed_d = armed_q;
        if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
        if (fill_q == 2'd2 && !sync2_q) armed_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign frame_tick = sync2_q & ~hist_q & armed_q;

endmodule

// File: rtl/player_action_sequencer.sv
// Per-frame player animation sequencer: latches button requests between frame
// ticks and advances state/sprite/actionable once per frame.
module player_action_sequencer
    import player_action_sequencer_pkg::*;
(
    input  logic                       sys_clk,
    input  logic                       rst_n,
    player_action_sequencer_if.slave   bus
);

    logic     frame_tick;
    pstate_e  state_q, state_d;
    pstate_e  sfb_q, sfb_d;
    pstate_e  req_state;
    sprite_t  sprite_q, sprite_d;
    logic     act_q, act_d;
    buttons_t latch_q, latch_d;

    frame_tick_gen u_frame_tick_gen (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .frame_clk  (bus.frame_clk),
        .frame_tick (frame_tick)
    );

    assign req_state = pstate_e'(bus.next_state);

    always_comb begin
        state_d = state_q;
        sprite_d = sprite_q;
        act_d = act_q;
        sfb_d = sfb_q;
        latch_d = latch_q | bus.player_buttons;
        if (frame_tick) begin
            // A press in the tick cycle is consumed here and not carried over
            sfb_d = button_priority(latch_q | bus.player_buttons);
            latch_d = '0;
            state_d = req_state;
            if (req_state != state_q || act_q) begin
                sprite_d = '0;
            end else if (sprite_q < last_sprite(state_q)) begin
                sprite_d = sprite_q + 1'b1;
            end
            if (state_d == ST_NOTHING) begin
                act_d = 1'b1;
            end else if (is_terminal(state_d)) begin
                act_d = 1'b0;
            end else begin
                act_d = (sprite_d == last_sprite(state_d));
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NOTHING;
            sprite_q <= '0;
            act_q    <= 1'b1;
            sfb_q    <= ST_NOTHING;
            latch_q  <= '0;
        end else begin
            state_q  <= state_d;
            sprite_q <= sprite_d;
            act_q    <= act_d;
            sfb_q    <= sfb_d;
            latch_q  <= latch_d;
        end
    end

    assign bus.player_state       = state_q;
    assign bus.player_sprite      = sprite_q;
    assign bus.player_actionable  = act_q;
    assign bus.state_from_buttons = sfb_q;
    assign bus.frame_tick         = frame_tick;

endmodule

// File: tb/tb_player_action_sequencer.sv
// Self-checking bench for player_action_sequencer with a frame-level model.
module tb_player_action_sequencer;

    logic sys_clk = 1'b0;
    logic rst_n;

    player_action_sequencer_if bus ();

    player_action_sequencer dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    int LEN [8] = '{1, 2, 2, 5, 4, 6, 8, 8};

    // Model of the player as seen at frame granularity
    int         m_state, m_sprite, m_act, m_sfb;
    logic [4:0] m_latch;
    int         since_rise;
    logic       prev_fclk;
    int         tick_seen;

    function automatic logic [9:0] model_vec();
        return {3'(m_state), 3'(m_sprite), 1'(m_act), 3'(m_sfb)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {bus.player_state, bus.player_sprite, bus.player_actionable, bus.state_from_buttons};
    endfunction

    task automatic model_reset();
        m_state = 0; m_sprite = 0; m_act = 1; m_sfb = 0;
        m_latch = '0; since_rise = -1;
    endtask

    task automatic model_tick(input logic [4:0] btns, input int ns);
        logic [4:0] req;
        int new_sprite;
        req = m_latch | btns;
        m_sfb = 0;
        for (int b = 0; b < 5; b++) if (req[b]) m_sfb = b + 1;
        if (ns != m_state || m_act == 1) new_sprite = 0;
        else if (m_sprite + 1 < LEN[m_state]) new_sprite = m_sprite + 1;
        else new_sprite = LEN[m_state] - 1;
        m_state = ns;
        m_sprite = new_sprite;
        if (ns == 0) m_act = 1;
        else if (ns >= 6) m_act = 0;
        else m_act = (new_sprite == LEN[ns] - 1) ? 1 : 0;
        m_latch = '0;
    endtask

    // One sys_clk cycle: drive at negedge, advance model at posedge, settle
    task automatic step(input logic [4:0] btns, input logic fclk, input int ns);
        @(negedge sys_clk);
        bus.player_buttons = btns;
        bus.frame_clk = fclk;
        bus.next_state = 3'(ns);
        if (fclk && !prev_fclk) since_rise = 0;
        prev_fclk = fclk;
        @(posedge sys_clk);
        if (since_rise == 2) begin
            model_tick(btns, ns);
            since_rise = -1;
        end else begin
            m_latch = m_latch | btns;
            if (since_rise >= 0) since_rise++;
        end
        #1;
        if (bus.frame_tick === 1'b1) tick_seen++;
    endtask

    task automatic frame(input int ns, input logic [4:0] btns);
        for (int i = 0; i < 4; i++) step((i < 3) ? btns : 5'd0, 1'b1, ns);
        for (int i = 0; i < 4; i++) step(5'd0, 1'b0, ns);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.frame_clk = 1'b0;
        bus.player_buttons = '0;
        bus.next_state = '0;
        prev_fclk = 1'b0;
        tick_seen = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        bus.frame_clk = 1'b1;
        bus.player_buttons = 5'b10000;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (dut_vec() !== {3'd0, 3'd0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {3'd0, 3'd0, 1'b1, 3'd0});
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick: got %b expected 0", bus.frame_tick);
        end
        @(negedge sys_clk);
        bus.frame_clk = 1'b0;
        bus.player_buttons = '0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(5'd0, 1'b0, 0);
        checks++;
        if (dut_vec() !== model_vec() || tick_seen != 0) begin
            failures++;
            $display("FAIL reset_release: got %h ticks %0d expected %h ticks 0", dut_vec(), tick_seen, model_vec());
        end
    endtask

    task automatic test_single_tick();
        int first;
        first = -1;
        tick_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(5'd0, (i < 4), 0);
            if (bus.frame_tick === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (tick_seen != 1) begin
            failures++;
            $display("FAIL single_tick_count: got %0d expected 1", tick_seen);
        end
        checks++;
        if (first + 1 != 2) begin
            failures++;
            $display("FAIL single_tick_latency: got %0d cycles expected 2", first + 1);
        end
        checks++;
        if (dut_vec() !== {3'd0, 3'd0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL single_tick_outputs: got %h expected %h", dut_vec(), {3'd0, 3'd0, 1'b1, 3'd0});
        end
    endtask

    task automatic test_kick_pulse();
        step(5'd0, 1'b0, 0);
        step(5'b10000, 1'b0, 0);
        step(5'd0, 1'b0, 0);
        frame(0, 5'd0);
        checks++;
        if (bus.state_from_buttons !== 3'd5 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL kick_pulse_latched: got sfb %0d vec %h expected sfb 5 vec %h", bus.state_from_buttons, dut_vec(), model_vec());
        end
        frame(0, 5'd0);
        checks++;
        if (bus.state_from_buttons !== 3'd0) begin
            failures++;
            $display("FAIL kick_pulse_cleared: got %0d expected 0", bus.state_from_buttons);
        end
    endtask

    task automatic test_priority();
        frame(0, 5'b11001);
        checks++;
        if (bus.state_from_buttons !== 3'd5 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL priority_kick: got %0d expected 5", bus.state_from_buttons);
        end
        frame(0, 5'b00011);
        checks++;
        if (bus.state_from_buttons !== 3'd2 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL priority_backwards: got %0d expected 2", bus.state_from_buttons);
        end
    endtask

    task automatic test_kick_sequence();
        int exp_spr [7] = '{0, 1, 2, 3, 4, 5, 0};
        int exp_act [7] = '{0, 0, 0, 0, 0, 1, 0};
        for (int k = 0; k < 7; k++) begin
            frame(5, 5'd0);
            checks++;
            if (bus.player_state !== 3'd5 || bus.player_sprite !== 3'(exp_spr[k]) ||
                bus.player_actionable !== 1'(exp_act[k]) || dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL kick_seq[%0d]: got state %0d sprite %0d act %b expected state 5 sprite %0d act %0d",
                         k, bus.player_state, bus.player_sprite, bus.player_actionable, exp_spr[k], exp_act[k]);
            end
        end
    endtask

    task automatic test_win();
        for (int k = 0; k < 10; k++) begin
            frame(6, 5'd0);
            checks++;
            if (bus.player_state !== 3'd6 || bus.player_sprite !== 3'((k < 7) ? k : 7) ||
                bus.player_actionable !== 1'b0 || dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL win_seq[%0d]: got state %0d sprite %0d act %b expected state 6 sprite %0d act 0",
                         k, bus.player_state, bus.player_sprite, bus.player_actionable, (k < 7) ? k : 7);
            end
        end
    endtask

    task automatic test_reset_mid_action();
        @(negedge sys_clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(5'd0, 1'b0, 0);
        for (int k = 0; k < 3; k++) frame(5, 5'd0);
        for (int i = 0; i < 4; i++) step(5'd0, 1'b1, 5);
        checks++;
        if (bus.player_state !== 3'd5 || bus.player_sprite !== 3'd3 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL mid_action_setup: got state %0d sprite %0d expected state 5 sprite 3", bus.player_state, bus.player_sprite);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {3'd0, 3'd0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL mid_action_abort: got %h expected %h", dut_vec(), {3'd0, 3'd0, 1'b1, 3'd0});
        end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick_seen = 0;
        for (int i = 0; i < 6; i++) step(5'd0, 1'b1, 5);
        checks++;
        if (tick_seen != 0 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL no_tick_on_high_level: got ticks %0d vec %h expected ticks 0 vec %h", tick_seen, dut_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) step(5'd0, 1'b0, 5);
        frame(5, 5'd0);
        checks++;
        if (tick_seen != 1 || bus.player_state !== 3'd5 || bus.player_sprite !== 3'd0 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL tick_after_fresh_edge: got ticks %0d state %0d sprite %0d expected ticks 1 state 5 sprite 0",
                     tick_seen, bus.player_state, bus.player_sprite);
        end
    endtask

    task automatic test_random();
        int ns;
        int hi, lo;
        logic [4:0] btn;
        ns = 0;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 2) == 0) ns = int'($urandom_range(0, 7));
            hi = int'($urandom_range(4, 6));
            lo = int'($urandom_range(2, 5));
            for (int i = 0; i < hi + lo; i++) begin
                btn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
                step(btn, (i < hi), ns);
                checks++;
                if (dut_vec() !== model_vec() || bus.frame_tick !== logic'(since_rise == 2)) begin
                    failures++;
                    $display("FAIL random[%0d.%0d]: got vec %h tick %b expected vec %h tick %b",
                             f, i, dut_vec(), bus.frame_tick, model_vec(), since_rise == 2);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_tick();
        test_kick_pulse();
        test_priority();
        test_kick_sequence();
        test_win();
        test_reset_mid_action();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
